// File: rtl/muldiv_pkg.sv
// Shared encodings for the sequential multiply/divide unit.
// Op codes, FSM states and small op-decode helpers.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Operand magnitude extraction and result sign correction.
// Purely combinational; shared by operand load and the FIX state.
module muldiv_sign_fix
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               i_signed,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    input  logic               i_div,
    input  logic               i_neg_q,
    input  logic               i_neg_r,
    input  logic [2*WIDTH-1:0] i_res,
    output logic               o_sa,
    output logic               o_sb,
    output logic [WIDTH-1:0]   o_mag_a,
    output logic [WIDTH-1:0]   o_mag_b,
    output logic [2*WIDTH-1:0] o_res
);

    logic [WIDTH-1:0] w_hi;
    logic [WIDTH-1:0] w_lo;

    always_comb begin
        o_sa    = i_signed & i_a[WIDTH-1];
        o_sb    = i_signed & i_b[WIDTH-1];
        o_mag_a = o_sa ? (-i_a) : i_a;
        o_mag_b = o_sb ? (-i_b) : i_b;
    end

    // Multiply negates the full product; divide fixes q and r separately.
    always_comb begin
        w_hi  = i_res[2*WIDTH-1:WIDTH];
        w_lo  = i_res[WIDTH-1:0];
        o_res = i_res;
        if (i_div) begin
            o_res = {i_neg_r ? (-w_hi) : w_hi,
                     i_neg_q ? (-w_lo) : w_lo};
        end else if (i_neg_q) begin
            o_res = -i_res;
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// One shift-add / restoring-divide step per cycle over WIDTH cycles.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div0
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_e             r_state;
    state_e             w_next;
    op_e                r_op;
    logic               r_sa;
    logic               r_sb;
    logic               r_dz;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_acc_hi;
    logic [WIDTH-1:0]   r_acc_lo;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_div0;

    logic               w_busy;
    logic               w_accept;
    logic               w_iter;
    logic               w_fix;
    logic               w_commit;
    logic               w_zero_div;
    logic               w_last;

    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [2*WIDTH-1:0] w_fixed;

    logic [WIDTH:0]     w_madd;
    logic [WIDTH:0]     w_msum;
    logic [WIDTH:0]     w_dshl;
    logic [WIDTH:0]     w_dsub;
    logic [WIDTH-1:0]   w_it_hi;
    logic [WIDTH-1:0]   w_it_lo;

    assign w_zero_div = op_is_div(op) && (b == '0);
    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

    muldiv_sign_fix #(
        .WIDTH (WIDTH)
    ) u_sign_fix (
        .i_signed (op_is_signed(op)),
        .i_a      (a),
        .i_b      (b),
        .i_div    (op_is_div(r_op)),
        .i_neg_q  (r_sa ^ r_sb),
        .i_neg_r  (r_sa),
        .i_res    ({r_acc_hi, r_acc_lo}),
        .o_sa     (w_sa),
        .o_sb     (w_sb),
        .o_mag_a  (w_mag_a),
        .o_mag_b  (w_mag_b),
        .o_res    (w_fixed)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_zero_div ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (w_last) begin
                    w_next = S_FIX;
                end
            end
            S_FIX:  w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
        endcase
        if (flush) begin
            w_next = S_IDLE;
        end
    end

    // r_done blocks a start landing in the same cycle as the done pulse.
    always_comb begin
        w_busy   = 1'b0;
        w_accept = 1'b0;
        w_iter   = 1'b0;
        w_fix    = 1'b0;
        w_commit = 1'b0;
        unique case (r_state)
            S_IDLE: w_accept = start & ~flush & ~r_done;
            S_CALC: begin
                w_busy = 1'b1;
                w_iter = ~flush;
            end
            S_FIX: begin
                w_busy = 1'b1;
                w_fix  = ~flush;
            end
            S_DONE: begin
                w_busy   = 1'b1;
                w_commit = ~flush;
            end
        endcase
    end

    always_comb begin
        w_madd  = {1'b0, r_acc_hi} + {1'b0, r_mcand};
        w_msum  = r_acc_lo[0] ? w_madd : {1'b0, r_acc_hi};
        w_dshl  = {r_acc_hi, r_acc_lo[WIDTH-1]};
        w_dsub  = w_dshl - {1'b0, r_mcand};
        w_it_hi = w_msum[WIDTH:1];
        w_it_lo = {w_msum[0], r_acc_lo[WIDTH-1:1]};
        if (op_is_div(r_op)) begin
            if (w_dsub[WIDTH]) begin
                w_it_hi = w_dshl[WIDTH-1:0];
                w_it_lo = {r_acc_lo[WIDTH-2:0], 1'b0};
            end else begin
                w_it_hi = w_dsub[WIDTH-1:0];
                w_it_lo = {r_acc_lo[WIDTH-2:0], 1'b1};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op     <= OP_MULT;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_dz     <= 1'b0;
            r_mcand  <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
            r_div0   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_div0 <= 1'b0;
            if (w_accept) begin
                r_op     <= op_e'(op);
                r_sa     <= w_sa;
                r_sb     <= w_sb;
                r_dz     <= w_zero_div;
                r_mcand  <= w_mag_b;
                r_acc_hi <= '0;
                r_acc_lo <= w_mag_a;
                r_cnt    <= '0;
            end else if (w_iter) begin
                r_acc_hi <= w_it_hi;
                r_acc_lo <= w_it_lo;
                r_cnt    <= r_cnt + CNT_W'(1);
            end else if (w_fix) begin
                {r_acc_hi, r_acc_lo} <= w_fixed;
            end
            if (w_commit) begin
                r_done <= 1'b1;
                r_div0 <= r_dz;
                if (!r_dz) begin
                    r_hi <= r_acc_hi;
                    r_lo <= r_acc_lo;
                end
            end
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign busy = w_busy;
    assign done = r_done;
    assign div0 = r_div0;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed table, corner
// sequences and random ops against a plain-arithmetic model.
module tb_muldiv_seq;

    localparam int W = 32;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         flush;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;
    logic         div0;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    vec_t         tbl[12];

    always #5 clk = ~clk;

    muldiv_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done),
        .div0  (div0)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic void model(input logic [1:0] o,
                                  input logic [W-1:0] x,
                                  input logic [W-1:0] y,
                                  output logic [W-1:0] rh,
                                  output logic [W-1:0] rl,
                                  output logic dz);
        longint       sx;
        longint       sy;
        logic [63:0]  p;
        logic [63:0]  r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        dz = 1'b0;
        rh = m_hi;
        rl = m_lo;
        p  = '0;
        r  = '0;
        case (o)
            2'b00: p = sx * sy;
            2'b01: p = {32'h0, x} * {32'h0, y};
            default: begin
                if (y == '0) dz = 1'b1;
                else if (o == 2'b10) begin
                    p = sx / sy;
                    r = sx % sy;
                    p = {r[31:0], p[31:0]};
                end else begin
                    p = {32'h0, x} / {32'h0, y};
                    r = {32'h0, x} % {32'h0, y};
                    p = {r[31:0], p[31:0]};
                end
            end
        endcase
        if (!dz) begin
            rh = p[63:32];
            rl = p[31:0];
        end
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input int inj,
                          input logic fl, output int lat);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        lat = -1;
        for (int n = 1; n <= 100 && lat < 0; n++) begin
            if (n == inj) begin
                if (fl) flush = 1'b1;
                else begin
                    start = 1'b1;
                    op    = 2'b11;
                    a     = 32'd1;
                    b     = 32'd1;
                end
            end
            @(posedge clk);
            @(negedge clk);
            if (n == inj) begin
                start = 1'b0;
                flush = 1'b0;
                if (fl) chk("flush_busy", 64'(busy), 64'd0);
            end
            if (done) lat = n;
        end
    endtask

    task automatic check_op(input string nm, input logic [1:0] o,
                            input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic [W-1:0] eh, input logic [W-1:0] el,
                            input logic edz, input int inj);
        int lat;
        run_op(o, x, y, inj, 1'b0, lat);
        chk({nm, "_lat"}, 64'(lat), edz ? 64'd1 : 64'(W + 2));
        chk({nm, "_hi"}, 64'(hi), 64'(eh));
        chk({nm, "_lo"}, 64'(lo), 64'(el));
        chk({nm, "_div0"}, 64'(div0), 64'(edz));
        m_hi = eh;
        m_lo = el;
        @(posedge clk);
        @(negedge clk);
        chk({nm, "_pulse"}, 64'({done, div0}), 64'd0);
    endtask

    initial begin
        logic [W-1:0] eh;
        logic [W-1:0] el;
        logic         edz;
        logic [1:0]   ro;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           lat;

        tbl[0]  = '{2'b00, 32'd7, 32'hFFFFFFFD,
                    32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        tbl[1]  = '{2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0};
        tbl[2]  = '{2'b10, 32'hFFFFFFF9, 32'd2,
                    32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        tbl[3]  = '{2'b10, 32'd5, 32'd0,
                    32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1};
        tbl[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF,
                    32'h0, 32'h80000000, 1'b0};
        tbl[5]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF,
                    32'hFFFFFFFE, 32'h1, 1'b0};
        tbl[6]  = '{2'b00, 32'h80000000, 32'h80000000,
                    32'h40000000, 32'h0, 1'b0};
        tbl[7]  = '{2'b10, 32'd7, 32'hFFFFFFFE,
                    32'd1, 32'hFFFFFFFD, 1'b0};
        tbl[8]  = '{2'b11, 32'hFFFFFFFF, 32'd1,
                    32'h0, 32'hFFFFFFFF, 1'b0};
        tbl[9]  = '{2'b11, 32'd0, 32'd0,
                    32'h0, 32'hFFFFFFFF, 1'b1};
        tbl[10] = '{2'b00, 32'hFFFFFFFF, 32'd1,
                    32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
        tbl[11] = '{2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE,
                    32'hFFFFFFFF, 32'd3, 1'b0};

        reset = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        #12;
        chk("reset_out", 64'({hi, lo}), 64'd0);
        chk("reset_flags", 64'({busy, done, div0}), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            check_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a,
                     tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].dz, 0);
        end

        model(2'b00, 32'd12345, 32'd678, eh, el, edz);
        check_op("ign_start", 2'b00, 32'd12345, 32'd678,
                 eh, el, edz, 5);

        run_op(2'b00, 32'd99, 32'd99, 10, 1'b1, lat);
        chk("flush_no_done", 64'(lat < 0), 64'd1);
        chk("flush_hilo", 64'({hi, lo}), 64'({m_hi, m_lo}));

        model(2'b01, 32'd11, 32'd13, eh, el, edz);
        run_op(2'b01, 32'd11, 32'd13, 0, 1'b0, lat);
        chk("sod_lat", 64'(lat), 64'(W + 2));
        chk("sod_lo", 64'(lo), 64'(el));
        m_hi  = eh;
        m_lo  = el;
        start = 1'b1;
        op    = 2'b01;
        a     = 32'd3;
        b     = 32'd5;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("start_on_done_ignored", 64'(busy), 64'd0);
        check_op("after_done", 2'b01, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = $urandom_range(1, 15);
                2: rb = 32'hFFFFFFFF;
                3: begin
                    ra = 32'h80000000;
                    rb = $urandom;
                end
                default: rb = $urandom;
            endcase
            model(ro, ra, rb, eh, el, edz);
            check_op($sformatf("rnd%0d", i), ro, ra, rb, eh, el, edz, 0);
        end

        check_op("pre_rst", 2'b01, 32'hFFFFFFFF, 32'd2,
                 32'd1, 32'hFFFFFFFE, 1'b0, 0);
        op    = 2'b00;
        a     = 32'd5;
        b     = 32'd9;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_out", 64'({hi, lo}), 64'd0);
        chk("midrst_flags", 64'({busy, done, div0}), 64'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        reset = 1'b0;
        check_op("post_rst", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF,
                 32'hFFFFFFFE, 32'h1, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width (even, >=4).
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request a new operation; honoured only while busy=0.
REQ-005 SHALL have port op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port a  input  WIDTH  multiplicand / dividend, sampled with start.
REQ-007 SHALL have port b  input  WIDTH  multiplier / divisor, sampled with start.
REQ-008 SHALL have port flush  input  1  synchronous abort of the operation in flight.
REQ-009 SHALL have port hi  output  WIDTH  HI register: product upper half / remainder.
REQ-010 SHALL have port lo  output  WIDTH  LO register: product lower half / quotient.
REQ-011 SHALL have port busy  output  1  high from the cycle after start is accepted until done.
REQ-012 SHALL have port done  output  1  one-cycle pulse; hi/lo updated in the same cycle.
REQ-013 SHALL have port div0  output  1  one-cycle pulse with done on a DIV/DIVU with b=0.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-015 IDLE: start=1 SHALL latch op/a/b and go to CALC; for DIV/DIVU with b=0 it SHALL go directly to DONE with div0 set.
REQ-016 CALC SHALL run exactly WIDTH iterations: shift-add for multiply, restoring shift-subtract for divide, on operand magnitudes for signed ops.
REQ-017 FIX SHALL apply sign correction for one cycle, then go to DONE.
REQ-018 DONE SHALL pulse done for one cycle, write hi/lo (not written on div0), then return to IDLE.
REQ-019 Latency SHALL be WIDTH+2 cycles from the start-sampling edge to done=1; div-by-zero latency SHALL be 1 cycle.
REQ-020 MULT/MULTU result SHALL be the exact 2*WIDTH-bit signed/unsigned product, split as {hi,lo}.
REQ-021 DIV quotient SHALL truncate toward zero; remainder sign SHALL equal the dividend sign.
REQ-022 DIV of most-negative by -1 SHALL give lo=most-negative (wrap), hi=0, with no div0.
REQ-023 start while busy=1 SHALL be ignored with no effect on the running operation.
REQ-024 flush SHALL return the FSM to IDLE next cycle, leave hi/lo unchanged, and suppress done/div0; flush has priority over start in the same cycle.
REQ-025 hi/lo SHALL hold their value between operations.
REQ-026 A start in the same cycle as done SHALL be ignored; a new start is accepted from the following IDLE cycle.

Reset
REQ-027 reset SHALL force IDLE, hi=0, lo=0, busy=0, done=0, div0=0, and clear the iteration counter, including mid-operation.
REQ-028 The first start SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-029 Op encodings and FSM state encodings SHALL reside in shared package muldiv_pkg.
REQ-030 Combinational magnitude/negate logic SHALL be a sub-module, muldiv_sign_fix; the FSM and iteration datapath SHALL stay in muldiv_seq.
REQ-031 The iteration counter SHALL be $clog2(WIDTH)+1 bits wide.

Verification
REQ-032 MULT a=7, b=-3 (WIDTH=32) -> done at cycle 34, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-033 DIVU a=100, b=7 -> lo=14, hi=2; DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-034 DIV a=5, b=0 with hi/lo preloaded -> done=div0=1 one cycle later, hi/lo unchanged.
REQ-035 DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div0=0.
REQ-036 Second start at cycle 5 of a MULT -> ignored, first result intact; flush at cycle 10 -> busy=0 next cycle, no done pulse.
REQ-037 reset asserted mid-CALC -> all outputs 0 immediately; a new MULTU 0xFFFFFFFF*0xFFFFFFFF afterwards -> hi=0xFFFFFFFE, lo=0x00000001.
